// File: rtl/mc_control.sv
// Multicycle MIPS-style main controller: Moore FSM producing datapath strobes.
// Optional jump support is enabled by defining MC_CONTROL_JUMP_EN.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       regdest,
  output logic       alusrca,
  output logic       aluop1,
  output logic       aluop2,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IXEC   = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
`ifdef MC_CONTROL_JUMP_EN
  localparam logic [5:0] OP_J   = 6'b000010;
`endif

  state_t cur, nxt;

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt         = FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    regdest     = 1'b0;
    alusrca     = 1'b0;
    aluop1      = 1'b0;
    aluop2      = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    state       = cur;

    case (cur)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        nxt     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = RXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_ORI:       nxt = IXEC;
`ifdef MC_CONTROL_JUMP_EN
          OP_J:         nxt = JUMP;
`endif
          default: begin
            illegal = 1'b1;
            nxt     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        nxt     = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        nxt        = mem_ready ? FETCH : MEMWR;
      end
      RXEC: begin
        alusrca = 1'b1;
        aluop1  = 1'b1;
        nxt     = RWB;
      end
      RWB: begin
        regwrite   = 1'b1;
        regdest    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop2      = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        instr_done  = 1'b1;
      end
      IXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop1  = 1'b1;
        aluop2  = 1'b1;
        nxt     = IWB;
      end
      IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MC_CONTROL_JUMP_EN
      JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
      end
`endif
      default: nxt = FETCH;
    endcase

    // Reset forces every output low combinationally, so an instruction caught
    // mid-flight cannot emit a write strobe in the reset cycle.
    if (reset) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      regdest     = 1'b0;
      alusrca     = 1'b0;
      aluop1      = 1'b0;
      aluop2      = 1'b0;
      alusrcb     = 2'b00;
      pcsource    = 2'b00;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      state       = '0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed, table-driven bench for mc_control plus latency and write-wait sequences.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regwrite, regdest, alusrca, aluop1, aluop2;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;
  logic       instr_done, illegal;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regwrite(regwrite), .regdest(regdest),
    .alusrca(alusrca), .aluop1(aluop1), .aluop2(aluop2),
    .alusrcb(alusrcb), .pcsource(pcsource), .state(state),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RF = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ORI = 6'b001101, BAD = 6'b111111, JOP = 6'b000010;

  localparam logic [17:0] PCW  = 18'h1 << 17, PWC = 18'h1 << 16, IORD = 18'h1 << 15;
  localparam logic [17:0] MR   = 18'h1 << 14, MW  = 18'h1 << 13, IRW  = 18'h1 << 12;
  localparam logic [17:0] M2R  = 18'h1 << 11, RW  = 18'h1 << 10, RD   = 18'h1 << 9;
  localparam logic [17:0] SA   = 18'h1 << 8,  A1  = 18'h1 << 7,  A2   = 18'h1 << 6;
  localparam logic [17:0] B4   = 18'h1 << 4,  BIMM = 18'h2 << 4, BSH  = 18'h3 << 4;
  localparam logic [17:0] PS1  = 18'h1 << 2,  PS2 = 18'h2 << 2;
  localparam logic [17:0] DONE = 18'h2,       ILL = 18'h1;
  localparam logic [17:0] F0 = MR | B4;
  localparam logic [17:0] F1 = MR | B4 | IRW | PCW;

  logic [17:0] got;
  assign got = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regwrite, regdest, alusrca, aluop1, aluop2, alusrcb, pcsource,
                instr_done, illegal};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] out;
  } vec_t;

  vec_t vecs[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic addv(input logic r, input logic [5:0] o, input logic m,
                      input logic [3:0] s, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = m; v.st = s; v.out = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs settle before the next rise.
  task automatic step(input logic r, input logic [5:0] o, input logic m);
    @(negedge clk);
    reset = r; op = o; mem_ready = m;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, mwcnt, rwcnt;
    logic [3:0] donepat;
    logic [5:0] lops [5];
    int         lats [5];

    addv(1, LW, 0, 0, '0);
    addv(1, LW, 1, 0, '0);
    // lw with a FETCH wait and a MEMRD wait; mem_ready ignored elsewhere
    addv(0, LW, 0, 0, F0);
    addv(0, LW, 1, 0, F1);
    addv(0, LW, 0, 1, BSH);
    addv(0, LW, 1, 2, SA | BIMM);
    addv(0, LW, 0, 3, MR | IORD);
    addv(0, LW, 1, 3, MR | IORD);
    addv(0, LW, 0, 4, RW | M2R | DONE);
    addv(0, SW, 1, 0, F1);
    addv(0, SW, 1, 1, BSH);
    addv(0, SW, 1, 2, SA | BIMM);
    addv(0, SW, 0, 5, MW | IORD);
    addv(0, SW, 1, 5, MW | IORD | DONE);
    addv(0, RF, 1, 0, F1);
    addv(0, RF, 1, 1, BSH);
    addv(0, RF, 1, 6, SA | A1);
    addv(0, RF, 0, 7, RW | RD | DONE);
    addv(0, BEQ, 1, 0, F1);
    addv(0, BEQ, 1, 1, BSH);
    addv(0, BEQ, 0, 8, SA | A2 | PWC | PS1 | DONE);
    addv(0, ORI, 1, 0, F1);
    addv(0, ORI, 1, 1, BSH);
    addv(0, ORI, 1, 9, SA | BIMM | A1 | A2);
    addv(0, ORI, 1, 10, RW | DONE);
    addv(0, BAD, 1, 0, F1);
    addv(0, BAD, 1, 1, BSH | ILL);
    addv(0, JOP, 1, 0, F1);
`ifdef MC_CONTROL_JUMP_EN
    addv(0, JOP, 1, 1, BSH);
    addv(0, JOP, 0, 11, PCW | PS2 | DONE);
`else
    addv(0, JOP, 1, 1, BSH | ILL);
`endif
    // reset during a pending MEMRD, then during a pending MEMWR
    addv(0, LW, 1, 0, F1);
    addv(0, LW, 1, 1, BSH);
    addv(0, LW, 1, 2, SA | BIMM);
    addv(0, LW, 0, 3, MR | IORD);
    addv(1, LW, 0, 0, '0);
    addv(0, SW, 1, 0, F1);
    addv(0, SW, 1, 1, BSH);
    addv(0, SW, 1, 2, SA | BIMM);
    addv(0, SW, 0, 5, MW | IORD);
    addv(1, SW, 1, 0, '0);
    addv(0, SW, 0, 0, F0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].rdy);
      chk($sformatf("vec%0d {state,outs}", i), {10'd0, state, got},
          {10'd0, vecs[i].st, vecs[i].out});
    end

    // Back-to-back latency with mem_ready held high
    lops = '{LW, SW, RF, ORI, BEQ};
    lats = '{5, 4, 4, 4, 3};
    step(0, LW, 1);
    chk("lat_start_state", {28'd0, state}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cnt = 1;
      for (int k = 0; k < 12; k++) begin
        step(0, lops[i], 1);
        if (state == 4'd0) break;
        cnt++;
      end
      chk($sformatf("latency_op%b", lops[i]), cnt, lats[i]);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, BEQ, 0);
      if (state == 4'd0) break;
    end

    // sw with three wait cycles in MEMWR
    mwcnt = 0; rwcnt = 0; donepat = '0;
    step(0, SW, 1);
    chk("sw_fetch_state", {28'd0, state}, 32'd0);
    step(0, SW, 1);
    if (regwrite) rwcnt++;
    step(0, SW, 1);
    if (regwrite) rwcnt++;
    for (int k = 0; k < 4; k++) begin
      step(0, SW, (k == 3));
      chk($sformatf("sw_wait%0d_state", k), {28'd0, state}, 32'd5);
      if (memwrite) mwcnt++;
      if (regwrite) rwcnt++;
      donepat[k] = instr_done;
    end
    step(0, SW, 0);
    chk("sw_after_state", {28'd0, state}, 32'd0);
    chk("sw_memwrite_cycles", mwcnt, 4);
    chk("sw_done_pattern", {28'd0, donepat}, 32'b1000);
    chk("sw_regwrite_cycles", rwcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, sole clock of block.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: op  input  6  instruction opcode field, from instruction register.
REQ-004 SHALL have port: mem_ready  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-005 SHALL have outputs, 1 bit each: pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regwrite, regdest, alusrca, aluop1, aluop2.
REQ-006 SHALL have outputs: alusrcb (2 bits: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate) and pcsource (2 bits: 00 ALU result, 01 ALUOut, 10 jump target).
REQ-007 SHALL have outputs: state (4 bits, current FSM state), instr_done (1-cycle pulse, instruction retired) and illegal (1-cycle pulse, unsupported opcode).

Function
REQ-008 SHALL be a Moore FSM. Only irwrite, pcwrite and instr_done are additionally qualified by mem_ready.
REQ-009 SHALL decode: R-format/srl = 000000, lw = 100011, sw = 101011, beq = 000100, ori = 001101.
REQ-010 SHALL encode states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RXEC=6, RWB=7, BRANCH=8, IXEC=9, IWB=10, JUMP=11. Codes 12-15 are unused.
REQ-011 In FETCH, SHALL assert memread, alusrcb=01 and pcsource=00. Only when mem_ready=1, SHALL also assert irwrite and pcwrite, then go to DECODE; otherwise stay in FETCH.
REQ-012 In DECODE, SHALL assert alusrcb=11.
REQ-013 From DECODE, SHALL branch by opcode: lw/sw→MEMADR; R→RXEC; beq→BRANCH; ori→IXEC.
REQ-014 From DECODE on any other opcode, SHALL pulse illegal for 1 cycle and go to FETCH.
REQ-015 In MEMADR, SHALL assert alusrca=1 and alusrcb=10, then go to MEMRD if lw, or MEMWR if sw.
REQ-016 In MEMRD, SHALL assert memread and iord, and hold in MEMRD until mem_ready=1, then go to MEMWB.
REQ-017 In MEMWB, SHALL assert regwrite and memtoreg, regdest=0, and pulse instr_done; next state FETCH.
REQ-018 In MEMWR, SHALL assert memwrite and iord, and hold until mem_ready=1. instr_done SHALL pulse in the cycle mem_ready=1; next state FETCH.
REQ-019 In RXEC, SHALL assert alusrca=1, alusrcb=00, aluop1=1; next state RWB.
REQ-020 In RWB, SHALL assert regwrite and regdest=1, pulse instr_done; next state FETCH.
REQ-021 In BRANCH, SHALL assert alusrca=1, alusrcb=00, aluop2=1, pcwritecond, pcsource=01, and pulse instr_done; next state FETCH.
REQ-022 In IXEC, SHALL assert alusrca=1, alusrcb=10, aluop1=1, aluop2=1; next state IWB.
REQ-023 In IWB, SHALL assert regwrite with regdest=0 and pulse instr_done; next state FETCH.
REQ-024 Every output not listed for a state SHALL be 0 in that state.
REQ-025 mem_ready SHALL be ignored in all states except FETCH, MEMRD and MEMWR.
REQ-026 An unused state code SHALL go to FETCH on the next edge with all outputs 0.
REQ-027 Instruction latency with mem_ready held at 1 SHALL be: lw 5 cycles, sw 4, R 4, ori 4, beq 3.

Reset
REQ-028 While reset=1, state SHALL load FETCH on each rising edge.
REQ-029 While reset=1, all outputs SHALL be 0 regardless of state or mem_ready.
REQ-030 Reset asserted mid-instruction, including during a pending memory wait, SHALL abandon the instruction without a regwrite, memwrite or pcwrite pulse.
REQ-031 The first cycle after reset deasserts SHALL be FETCH with memread=1.

Configuration
REQ-032 Macro MC_CONTROL_JUMP_EN, when defined, SHALL decode j = 000010 in DECODE to go to JUMP.
REQ-033 In JUMP, SHALL assert pcwrite with pcsource=10 and pulse instr_done; next state FETCH.
REQ-034 Without MC_CONTROL_JUMP_EN, opcode 000010 SHALL be illegal per REQ-014, and state 11 SHALL be treated as unused per REQ-026.

Verification
REQ-035 Reset 2 cycles, then mem_ready=1, op=100011 → state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; instr_done high exactly once.
REQ-036 op=101011, mem_ready=0 for 3 cycles in MEMWR then 1 → memwrite high 4 cycles; instr_done pulses only in the 4th cycle; regwrite never high.
REQ-037 op=000100 → states 0,1,8,0; in state 8 pcwritecond=1, pcsource=01, aluop2=1, aluop1=0.
REQ-038 op=001101 → states 0,1,9,10,0; aluop1=aluop2=1 in state 9; regwrite=1 with regdest=0 in state 10.
REQ-039 op=111111 → illegal pulses in state 1, then FETCH. op=000010 → same result without the macro; with MC_CONTROL_JUMP_EN, states 0,1,11,0 and pcsource=10.
REQ-040 reset=1 asserted in MEMRD with mem_ready=0 → next state 0; all outputs 0 during reset; no write strobe pulses.
